// File: rtl/commit_trace_fifo.sv
// Retirement-record FIFO fed by the core commit port, drained over valid/ready.
// Tracks sticky overflow, a saturating drop counter and a free-running commit counter.
module commit_trace_fifo #(
  parameter int DEPTH     = 8,
  parameter bit FILTER_X0 = 1'b1,
  parameter int CNT_W     = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_wr,
  input  logic [4:0]       commit_wr_idx,
  input  logic [31:0]      commit_wr_data,
  input  logic [31:0]      commit_npc,
  input  logic             flush,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [4:0]       trace_idx,
  output logic [31:0]      trace_data,
  output logic [31:0]      trace_npc,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [31:0]      commit_cnt
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [68:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [68:0]   head;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;

  always_comb begin
    push_req = commit_wr & ~(FILTER_X0 & (commit_wr_idx == 5'd0));
    pop      = trace_valid & trace_ready;
    full     = (level == FULL_LEVEL);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  // Storage is not reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= {commit_wr_idx, commit_wr_data, commit_npc};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt <= '0;
    end else if (commit_wr) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

  always_comb begin
    trace_valid = (level != '0);
    head        = mem[rd_ptr];
    trace_idx   = '0;
    trace_data  = '0;
    trace_npc   = '0;
    if (trace_valid) begin
      trace_idx  = head[68:64];
      trace_data = head[63:32];
      trace_npc  = head[31:0];
    end
  end

endmodule
